mash_dsm_param: RTL and testbench

- Parametrised MASH delta-sigma modulator for the fractional-N divider control path. It supersedes the fixed 16-bit, third-order core.
- Order is selectable at runtime (1, 2 or 3). Accumulator and output widths are set by parameters. LFSR LSB dither is optional.
- The integer/fraction word is double-buffered and loaded through a valid/ready handshake. The output is clamped, and a sticky saturation flag reports any clamp.
- Sits between the channel/frequency-control register block and the multi-modulus divider. Produces one divide-ratio word per clock.

---
 rtl/mash_dsm_pkg.sv | 35 +++
 rtl/mash_acc_stage.sv | 34 +++
 rtl/mash_dsm_param.sv | 164 ++++++++++++++++
 tb/tb_mash_dsm_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mash_dsm_pkg.sv
// Shared constants and helpers for the parametrised MASH delta-sigma modulator.
// Holds the order encodings, LFSR taps, the f width and the clamp helper.
package mash_dsm_pkg;

   localparam logic [1:0] ORD1 = 2'd1;
   localparam logic [1:0] ORD2 = 2'd2;
   localparam logic [1:0] ORD3 = 2'd3;

   // Fibonacci taps 16, 14, 13, 11 mapped onto bits 15, 13, 12, 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int F_W = 4;

   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_LOAD = 1'b1
   } hs_state_e;

   function automatic logic [1:0] norm_order(input logic [1:0] ord);
      return (ord == 2'd0) ? ORD1 : ord;
   endfunction

   function automatic logic signed [F_W-1:0] bit_to_f(input logic b);
      return {{(F_W-1){1'b0}}, b};
   endfunction

   function automatic logic signed [31:0] clamp_range(input logic signed [31:0] v,
                                                      input logic signed [31:0] lo,
                                                      input logic signed [31:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One MASH accumulator stage: ACC_W-bit wrapping adder with registered sum and carry.
// clr forces the stage to zero regardless of en.
module mash_acc_stage #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [ACC_W-1:0] addend,
   input  logic             cin,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] total;

   // addend + cin never exceeds 2^ACC_W, so the overflow still fits in one carry bit.
   assign total = {1'b0, sum} + {1'b0, addend} + {{ACC_W{1'b0}}, cin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum   <= '0;
         carry <= 1'b0;
      end else if (clr) begin
         sum   <= '0;
         carry <= 1'b0;
      end else if (en) begin
         sum   <= total[ACC_W-1:0];
         carry <= total[ACC_W];
      end
   end

endmodule

// File: rtl/mash_dsm_param.sv
// Runtime-order (1..3) MASH delta-sigma modulator driving the multi-modulus divider.
// Double-buffered integer/fraction config, clamped output and sticky saturation flag.
module mash_dsm_param
   import mash_dsm_pkg::*;
#(
   parameter int          ACC_W     = 16,
   parameter int          INT_W     = 4,
   parameter int          OUT_W     = 5,
   parameter int          DITHER_EN = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [INT_W-1:0] cfg_int,
   input  logic [ACC_W-1:0] cfg_frac,
   input  logic [1:0]       cfg_order,
   output logic [OUT_W-1:0] out,
   output logic             sat,
   output logic             dbg_state
);

   localparam logic signed [31:0] OUT_MAX = (32'sd1 <<< OUT_W) - 32'sd1;

   hs_state_e state_q, state_d;

   logic             accept, apply, order_chg;
   logic [INT_W-1:0] sh_int, act_int;
   logic [ACC_W-1:0] sh_frac, act_frac;
   logic [1:0]       sh_order, act_order;
   logic             on2, on3;

   logic [15:0]      lfsr_q;
   logic             lfsr_fb, dither;

   logic [ACC_W-1:0] s1_sum, s2_sum, s3_sum;
   logic             c1, c2, c3;
   logic             c1_d1, c1_d2, c2_d1, c2_d2, c3_d1, c3_d2;
   logic [INT_W-1:0] int_d1, int_d2;

   logic signed [F_W-1:0] f;
   logic signed [31:0]    sum32, clamp_w;
   logic                  clamp_hit;

   // Handshake: a config transfers on any edge with cfg_valid && cfg_ready; the
   // shadow is copied to active on the following edge, during which cfg_ready is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= HS_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HS_IDLE: if (cfg_valid) state_d = HS_LOAD;
         HS_LOAD: state_d = HS_IDLE;
         default: state_d = HS_IDLE;
      endcase
   end

   assign cfg_ready = (state_q == HS_IDLE);
   assign dbg_state = state_q;
   assign accept    = cfg_valid && cfg_ready;
   assign apply     = (state_q == HS_LOAD);
   assign order_chg = apply && (sh_order != act_order);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_int    <= '0;
         sh_frac   <= '0;
         sh_order  <= '0;
         act_int   <= '0;
         act_frac  <= '0;
         act_order <= ORD3;
      end else begin
         if (accept) begin
            sh_int   <= cfg_int;
            sh_frac  <= cfg_frac;
            sh_order <= norm_order(cfg_order);
         end
         if (apply) begin
            act_int   <= sh_int;
            act_frac  <= sh_frac;
            act_order <= sh_order;
         end
      end
   end

   assign on2 = (act_order != ORD1);
   assign on3 = (act_order == ORD3);

   assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);
   assign dither  = (DITHER_EN != 0) ? lfsr_q[0] : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     lfsr_q <= LFSR_SEED;
      else if (en) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
   end

   mash_acc_stage #(.ACC_W(ACC_W)) u_acc1 (
      .clk(clk), .rst(rst), .en(en), .clr(order_chg),
      .addend(act_frac), .cin(dither), .sum(s1_sum), .carry(c1)
   );

   mash_acc_stage #(.ACC_W(ACC_W)) u_acc2 (
      .clk(clk), .rst(rst), .en(en), .clr(order_chg || !on2),
      .addend(s1_sum), .cin(1'b0), .sum(s2_sum), .carry(c2)
   );

   mash_acc_stage #(.ACC_W(ACC_W)) u_acc3 (
      .clk(clk), .rst(rst), .en(en), .clr(order_chg || !on3),
      .addend(s2_sum), .cin(1'b0), .sum(s3_sum), .carry(c3)
   );

   // Carry history aligns the pipelined stages so latency is the same for every order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {c1_d1, c1_d2, c2_d1, c2_d2, c3_d1, c3_d2} <= '0;
      end else if (order_chg) begin
         {c1_d1, c1_d2, c2_d1, c2_d2, c3_d1, c3_d2} <= '0;
      end else if (en) begin
         c1_d1 <= c1;
         c1_d2 <= c1_d1;
         c2_d1 <= c2;
         c2_d2 <= c2_d1;
         c3_d1 <= c3;
         c3_d2 <= c3_d1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_d1 <= '0;
         int_d2 <= '0;
      end else if (en) begin
         int_d1 <= act_int;
         int_d2 <= int_d1;
      end
   end

   // Disabled stages hold zero carries, so the full third-order combine covers all orders.
   always_comb begin
      f = bit_to_f(c1_d2) + bit_to_f(c2_d1) - bit_to_f(c2_d2)
        + bit_to_f(c3) - (bit_to_f(c3_d1) <<< 1) + bit_to_f(c3_d2);
   end

   assign sum32     = $signed({{(32-INT_W){1'b0}}, int_d2}) + $signed({{(32-F_W){f[F_W-1]}}, f});
   assign clamp_w   = clamp_range(sum32, 32'sd0, OUT_MAX);
   assign clamp_hit = (clamp_w != sum32);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     out <= '0;
      else if (en) out <= OUT_W'(clamp_w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  sat <= 1'b0;
      else if (accept)          sat <= 1'b0;
      else if (en && clamp_hit) sat <= 1'b1;
   end

endmodule

// File: tb/tb_mash_dsm_param.sv
// Directed bench for mash_dsm_param: latency, patterns, mean, handshake, freeze, saturation, reset.
module tb_mash_dsm_param;

   logic        clk = 1'b0;
   logic        rst, en, cfg_valid;
   logic [3:0]  cfg_int;
   logic [15:0] cfg_frac;
   logic [1:0]  cfg_order;
   logic        cfg_ready, sat, dbg_state;
   logic [4:0]  out;
   logic        ready_s, sat_s, dbg_s;
   logic [3:0]  out_s;

   int     checks = 0;
   int     errors = 0;
   int     n, k;
   longint sum, mn, mx;

   always #5 clk = ~clk;

   mash_dsm_param #(.ACC_W(16), .INT_W(4), .OUT_W(5)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_order(cfg_order),
      .out(out), .sat(sat), .dbg_state(dbg_state)
   );

   mash_dsm_param #(.ACC_W(16), .INT_W(4), .OUT_W(4)) dut_s (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(ready_s),
      .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_order(cfg_order),
      .out(out_s), .sat(sat_s), .dbg_state(dbg_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic accept(input logic [3:0] i, input logic [15:0] fr, input logic [1:0] o);
      cfg_valid = 1'b1;
      cfg_int   = i;
      cfg_frac  = fr;
      cfg_order = o;
      step();
      cfg_valid = 1'b0;
   endtask

   // Order 1, frac 1/4: carry first appears 4 edges after apply, visible 3 edges later.
   function automatic logic [31:0] q_exp(input int idx);
      return (idx >= 7 && (idx - 7) % 4 == 0) ? 32'd8 : 32'd7;
   endfunction

   task automatic const_run(input logic [1:0] o);
      do_reset();
      accept(4'd7, 16'h0000, o);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("const_lat", 32'(out), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         chk("const_val", 32'(out), 32'd7);
      end
      chk("const_sat", 32'(sat), 32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      cfg_int = '0; cfg_frac = '0; cfg_order = '0;
      step();
      step();
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_acc1", 32'(dut.s1_sum), 32'd0);
      rst = 1'b0;
      en  = 1'b1;

      const_run(2'd3);
      const_run(2'd1);

      // Quarter fraction, then freeze, then handshake on identical config.
      do_reset();
      accept(4'd7, 16'h4000, 2'd1);
      step();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         n++;
         step();
         if (n >= 3) chk("q_pat", 32'(out), q_exp(n));
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("frz_out", 32'(out), 32'd7);
         chk("frz_acc", 32'(dut.s1_sum), 32'h8000);
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n++;
         step();
         chk("resume_pat", 32'(out), q_exp(n));
      end
      cfg_valid = 1'b1;
      chk("hs_rdy0", 32'(cfg_ready), 32'd1);
      n++; step();
      chk("hs_pat", 32'(out), q_exp(n));
      chk("hs_rdy1", 32'(cfg_ready), 32'd0);
      n++; step();
      chk("hs_pat", 32'(out), q_exp(n));
      chk("hs_rdy2", 32'(cfg_ready), 32'd1);
      n++; step();
      chk("hs_pat", 32'(out), q_exp(n));
      chk("hs_rdy3", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n++;
         step();
         chk("hs_cont", 32'(out), q_exp(n));
      end

      // Order 3 mean over a full 2^16 window.
      do_reset();
      accept(4'd8, 16'h2000, 2'd3);
      for (int i = 0; i < 3; i++) step();
      sum = 0; mn = 99; mx = 0;
      for (int i = 0; i < 65536; i++) begin
         step();
         sum += longint'(out);
         if (longint'(out) < mn) mn = longint'(out);
         if (longint'(out) > mx) mx = longint'(out);
      end
      chk_rng("mean_sum", sum, 64'd532476, 64'd532484);
      chk_rng("mean_min", mn, 64'd5, 64'd12);
      chk_rng("mean_max", mx, 64'd5, 64'd12);

      // Order change 3 -> 2 clears the accumulators on the apply edge.
      accept(4'd8, 16'h2000, 2'd2);
      step();
      chk("oc_acc1", 32'(dut.s1_sum), 32'd0);
      chk("oc_acc2", 32'(dut.s2_sum), 32'd0);
      chk("oc_acc3", 32'(dut.s3_sum), 32'd0);
      step();
      chk("oc_acc1_next", 32'(dut.s1_sum), 32'h2000);
      chk("oc_acc2_next", 32'(dut.s2_sum), 32'd0);
      chk("oc_acc3_next", 32'(dut.s3_sum), 32'd0);

      // Saturation on the 4-bit output instance.
      do_reset();
      accept(4'd15, 16'hFFFF, 2'd3);
      chk("sat_start", 32'(sat_s), 32'd0);
      k = 0;
      while (!sat_s && k < 12) begin
         step();
         k++;
      end
      chk("sat_rise", 32'(sat_s), 32'd1);
      chk("sat_out", 32'(out_s), 32'd15);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("sat_hold", 32'(sat_s), 32'd1);
      end
      accept(4'd5, 16'hFFFF, 2'd3);
      chk("sat_accept_clr", 32'(sat_s), 32'd0);
      for (int i = 0; i < 4; i++) step();

      // Asynchronous reset between edges with a pending shadow config.
      accept(4'd9, 16'h0000, 2'd3);
      chk("pend_rdy", 32'(cfg_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out", 32'(out), 32'd0);
      chk("arst_out_s", 32'(out_s), 32'd0);
      chk("arst_sat_s", 32'(sat_s), 32'd0);
      chk("arst_ready", 32'(cfg_ready), 32'd1);
      chk("arst_ready_s", 32'(ready_s), 32'd1);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("drop_out", 32'(out), 32'd0);
      end
      chk("drop_state", 32'(dbg_state), 32'd0);
      chk("drop_state_s", 32'(dbg_s), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
